// File: rtl/sic1_host_if.sv
// Stream bundle between the SIC-1 host and its environment: the program-byte
// input stream (s_*) and the captured-output byte stream (m_*).
interface sic1_host_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  // Environment side: feeds program bytes, consumes output bytes.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  // Host side: accepts program bytes, offers output bytes.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/sic1_host.sv
// SIC-1 host: loads a program into the target byte by byte using timed
// address/data strobes, runs it, and captures its output bytes through a
// 4-phase ack handshake into a first-word-fall-through FIFO.
module sic1_host #(
  parameter int STROBE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base_addr,
  sic1_host_if.slave  bus,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tgt_ui,
  output logic [3:0]  tgt_ctl,
  input  logic [7:0]  tgt_uo,
  input  logic        tgt_out_valid,
  input  logic        tgt_halted
);

  localparam int DATA_W = 8;
  localparam int CW     = 4;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, GAP_A, WAIT_BYTE, DATA, GAP_D, RUN, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                ack_q;
  logic                wait_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   byte_q;
  logic                last_q;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         fcnt_q;

  logic strobe_end, start_ok, s_hs, cap, full, empty, push, pop, s_rdy;

  assign strobe_end = (cnt_q == CW'(STROBE_CYCLES - 1));
  assign start_ok   = start && (state_q == IDLE || state_q == DONE);
  assign s_hs       = (state_q == WAIT_BYTE) && bus.s_valid;
  assign full       = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty      = (fcnt_q == '0);
  // A new capture needs the previous ack and its deassert wait to be over.
  assign cap        = (state_q == RUN) && tgt_out_valid && !ack_q && !wait_q && !full;
  assign push       = cap;
  assign pop        = !empty && bus.m_ready;

  assign bus.s_ready = s_rdy;
  assign bus.m_valid = !empty;
  assign bus.m_data  = empty ? '0 : mem_q[rd_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)      state_d = ADDR;
      ADDR:       if (strobe_end) state_d = GAP_A;
      GAP_A:                      state_d = WAIT_BYTE;
      WAIT_BYTE:  if (s_hs)       state_d = DATA;
      DATA:       if (strobe_end) state_d = GAP_D;
      GAP_D:                      state_d = last_q ? RUN : WAIT_BYTE;
      RUN:        if (tgt_halted && !ack_q && !wait_q && !cap) state_d = DONE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; strobes are mutually exclusive by construction.
  always_comb begin
    tgt_ui  = '0;
    tgt_ctl = '0;
    s_rdy   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ADDR:      begin tgt_ui = addr_q; tgt_ctl[0] = 1'b1; busy = 1'b1; end
      GAP_A:     begin tgt_ui = addr_q; busy = 1'b1; end
      WAIT_BYTE: begin s_rdy = 1'b1; busy = 1'b1; end
      DATA:      begin tgt_ui = byte_q; tgt_ctl[1] = 1'b1; busy = 1'b1; end
      GAP_D:     begin tgt_ui = byte_q; busy = 1'b1; end
      RUN:       begin tgt_ctl[2] = 1'b1; tgt_ctl[3] = ack_q; busy = 1'b1; end
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // Strobe timing and output ack/deassert-wait sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      if (state_q != state_d || cap || (ack_q && strobe_end))
        cnt_q <= '0;
      else if (state_q == ADDR || state_q == DATA || ack_q)
        cnt_q <= cnt_q + CW'(1);

      if (cap)
        ack_q <= 1'b1;
      else if (ack_q && strobe_end) begin
        ack_q  <= 1'b0;
        wait_q <= tgt_out_valid;
      end else if (wait_q && !tgt_out_valid)
        wait_q <= 1'b0;
    end
  end

  // Latched session address and program byte (data path, no reset needed).
  always_ff @(posedge clk) begin
    if (start_ok) addr_q <= base_addr;
    if (s_hs) begin
      byte_q <= bus.s_data;
      last_q <= bus.s_last;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tgt_uo;
  end

  // FIFO pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + (AW+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (AW+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sic1_host.sv
module tb_sic1_host;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic       busy, done;
  logic [7:0] tgt_ui;
  logic [3:0] tgt_ctl;
  logic [7:0] tgt_uo;
  logic       tgt_out_valid;
  logic       tgt_halted;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  sic1_host_if bus();

  sic1_host #(.STROBE_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .tgt_ui(tgt_ui), .tgt_ctl(tgt_ctl),
    .tgt_uo(tgt_uo), .tgt_out_valid(tgt_out_valid), .tgt_halted(tgt_halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // At most one of addr/data/ack strobes may be high in any cycle.
  always @(negedge clk) begin
    n_cmp++;
    assert ($countones(tgt_ctl & 4'b1011) <= 1) else begin
      n_err++;
      $error("FAIL onehot: observed %b expected at most one strobe", tgt_ctl);
    end
  end

  // Wait for strobe bit to rise, then report its length and the byte it carried.
  task automatic pulse(input int b, input string tag, input logic [7:0] ui_exp);
    int n;
    int len;
    logic [7:0] ui;
    n = 0;
    while (!tgt_ctl[b] && n < 30) begin tick(); n++; end
    chk({tag, " seen"}, 32'(tgt_ctl[b]), 32'd1);
    ui  = tgt_ui;
    len = 0;
    while (tgt_ctl[b] && len < 30) begin
      if (b != 3) chk({tag, " ui"}, 32'(tgt_ui), 32'(ui_exp));
      len++;
      tick();
    end
    chk({tag, " len"}, 32'(len), 32'd2);
    if (b != 3) chk({tag, " first ui"}, 32'(ui), 32'(ui_exp));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    while (!bus.s_ready && n < 30) begin tick(); n++; end
    chk("s_ready before byte", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    tick();
    bus.s_valid = 1'b0;
  endtask

  // Load one byte and check its strobe, gap, and the return to WAIT_BYTE or RUN.
  task automatic load_byte(input logic [7:0] d, input logic l);
    send_byte(d, l);
    pulse(1, "data", d);
    chk("gap_d ctl", 32'(tgt_ctl), 32'h0);
    chk("gap_d ui", 32'(tgt_ui), 32'(d));
    tick();
    if (l) chk("run ctl", 32'(tgt_ctl), 32'h4);
    else   chk("wait s_ready", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic present_acked(input logic [7:0] d);
    tgt_uo        = d;
    tgt_out_valid = 1'b1;
    exp_q.push_back(d);
    pulse(3, "ack", 8'h00);
    tgt_out_valid = 1'b0;
    tick();
  endtask

  // Pop n bytes with m_ready high, comparing each against the scoreboard.
  task automatic drain(input int cnt);
    int n;
    logic [7:0] e;
    bus.m_ready = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      while (!bus.m_valid && n < 20) begin tick(); n++; end
      chk("m_valid on drain", 32'(bus.m_valid), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk("m_data order", 32'(bus.m_data), 32'(e));
      tick();
    end
    bus.m_ready = 1'b0;
  endtask

  initial begin
    int n;
    int acks;
    rst = 1'b1; start = 1'b0; base_addr = '0;
    tgt_uo = '0; tgt_out_valid = 1'b0; tgt_halted = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset tgt_ctl", 32'(tgt_ctl), 32'h0);
    chk("reset tgt_ui", 32'(tgt_ui), 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset m_data", 32'(bus.m_data), 32'h0);
    chk("reset s_ready", 32'(bus.s_ready), 32'd0);

    // Load session at 0x10
    start = 1'b1; base_addr = 8'h10;
    tick();
    start = 1'b0; base_addr = 8'h00;
    chk("busy after start", 32'(busy), 32'd1);
    pulse(0, "addr", 8'h10);
    chk("gap_a ctl", 32'(tgt_ctl), 32'h0);
    chk("gap_a ui", 32'(tgt_ui), 32'h10);
    tick();
    chk("wait s_ready", 32'(bus.s_ready), 32'd1);
    load_byte(8'hA1, 1'b0);

    // Idle stream plus an ignored start while waiting for a byte
    start = 1'b1; base_addr = 8'h77;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall ctl", 32'(tgt_ctl), 32'h0);
      chk("stall s_ready", 32'(bus.s_ready), 32'd1);
      tick();
    end
    load_byte(8'hB2, 1'b0);
    load_byte(8'hC3, 1'b1);
    chk("run s_ready", 32'(bus.s_ready), 32'd0);
    chk("run busy", 32'(busy), 32'd1);

    // Output capture with full FIFO stall
    present_acked(8'h41);
    present_acked(8'h42);
    present_acked(8'h43);
    present_acked(8'h44);
    chk("fwft m_valid", 32'(bus.m_valid), 32'd1);
    chk("fwft m_data", 32'(bus.m_data), 32'h41);
    tgt_uo = 8'h45; tgt_out_valid = 1'b1;
    exp_q.push_back(8'h45);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (tgt_ctl[3]) acks++;
      tick();
    end
    chk("ack withheld when full", 32'(acks), 32'd0);
    drain(1);
    pulse(3, "ack after pop", 8'h00);
    tgt_out_valid = 1'b0;
    tick();
    drain(4);
    chk("empty after drain", 32'(bus.m_valid), 32'd0);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    // Halt during an ack: DONE waits for out_valid to drop
    tgt_uo = 8'h46; tgt_out_valid = 1'b1;
    exp_q.push_back(8'h46);
    n = 0;
    while (!tgt_ctl[3] && n < 20) begin tick(); n++; end
    chk("halt ack seen", 32'(tgt_ctl[3]), 32'd1);
    tgt_halted = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("halt hold run", 32'(tgt_ctl[2]), 32'd1);
      chk("halt hold done", 32'(done), 32'd0);
      tick();
    end
    tgt_out_valid = 1'b0;
    chk("done before drop", 32'(done), 32'd0);
    n = 0;
    while (!done && n < 10) begin tick(); n++; end
    chk("done", 32'(done), 32'd1);
    chk("done busy", 32'(busy), 32'd0);
    chk("done ctl", 32'(tgt_ctl), 32'h0);
    tgt_halted = 1'b0;

    // New start keeps FIFO contents; reset mid data strobe clears everything
    start = 1'b1; base_addr = 8'h20;
    tick();
    start = 1'b0;
    chk("restart done cleared", 32'(done), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    chk("fifo persists", 32'(bus.m_valid), 32'd1);
    chk("fifo persists data", 32'(bus.m_data), 32'h46);
    pulse(0, "addr2", 8'h20);
    send_byte(8'h5A, 1'b0);
    chk("in data strobe", 32'(tgt_ctl), 32'h2);
    rst = 1'b1;
    tick();
    chk("rst ctl", 32'(tgt_ctl), 32'h0);
    chk("rst ui", 32'(tgt_ui), 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst m_data", 32'(bus.m_data), 32'h0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    start = 1'b1; base_addr = 8'h33;
    tick();
    start = 1'b0;
    pulse(0, "addr3", 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
